// File: rtl/dmem_requester.sv
`default_nettype none
// ============================================================================
// Module      : dmem_requester
// Description : Initiator side of the mem_itf data port. Accepts a single
//               RV32I load/store from the LSU, issues one aligned word request
//               (addr/rmask/wmask/wdata) for exactly one cycle, waits for
//               mem_resp, then returns aligned and extended load data with
//               the request tag. Misaligned or illegal-funct3 requests never
//               reach memory, and a watchdog aborts a stalled memory.
// Ports       : clk, rst_n               clock, async active-low reset
//               req_valid/req_ready      LSU request handshake
//               req_we/funct3/addr/wdata/tag  request payload
//               flush                    discard in-flight/pending response
//               rsp_valid/rsp_ready      LSU response handshake
//               rsp_data/rsp_tag/rsp_exc response payload
//               timeout_err              sticky watchdog flag
//               mem_addr/rmask/wmask/wdata  memory request (one-cycle masks)
//               mem_rdata/mem_resp       memory completion
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_requester #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_exc,
  output logic             timeout_err,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_rmask,
  output logic [3:0]       mem_wmask,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_resp
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             r_state,       w_state_nxt;
  logic               r_kill,        w_kill_nxt;
  logic               r_timeout_err, w_timeout_err_nxt;
  logic [1:0]         r_off,         w_off_nxt;
  logic [2:0]         r_funct3,      w_funct3_nxt;
  logic               r_we,          w_we_nxt;
  logic [CNT_W-1:0]   r_cnt,         w_cnt_nxt;
  logic [31:0]        r_mem_addr,    w_mem_addr_nxt;
  logic [3:0]         r_mem_rmask,   w_mem_rmask_nxt;
  logic [3:0]         r_mem_wmask,   w_mem_wmask_nxt;
  logic [31:0]        r_mem_wdata,   w_mem_wdata_nxt;
  logic               r_rsp_valid,   w_rsp_valid_nxt;
  logic [31:0]        r_rsp_data,    w_rsp_data_nxt;
  logic [TAG_W-1:0]   r_rsp_tag,     w_rsp_tag_nxt;
  logic               r_rsp_exc,     w_rsp_exc_nxt;

  logic [1:0]  w_size;
  logic [1:0]  w_req_off;
  logic        w_illegal;
  logic        w_misal;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_rdata_sh;
  logic [31:0] w_load_data;
  logic        w_kill_eff;
  logic        w_accept;

  assign req_ready   = (r_state == ST_IDLE) && !flush;
  assign w_accept    = req_valid && req_ready;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_tag     = r_rsp_tag;
  assign rsp_exc     = r_rsp_exc;
  assign timeout_err = r_timeout_err;
  assign mem_addr    = r_mem_addr;
  assign mem_rmask   = r_mem_rmask;
  assign mem_wmask   = r_mem_wmask;
  assign mem_wdata   = r_mem_wdata;

  // Request decode: funct3[1:0] is the access size, funct3[2] the unsigned flag.
  assign w_size     = req_funct3[1:0];
  assign w_req_off  = req_addr[1:0];
  assign w_illegal  = req_we ? (req_funct3[2] || (w_size == 2'b11))
                             : ((w_size == 2'b11) || (req_funct3[2] && req_funct3[1]));
  assign w_misal    = ((w_size == 2'b01) && w_req_off[0]) ||
                      ((w_size == 2'b10) && (w_req_off != 2'b00));
  assign w_wdata_sh = req_wdata << {w_req_off, 3'b000};

  always_comb begin
    w_mask = 4'b1111;
    case (w_size)
      2'b00:   w_mask = 4'b0001 << w_req_off;
      2'b01:   w_mask = 4'b0011 << w_req_off;
      default: w_mask = 4'b1111;
    endcase
  end

  // Load extraction uses the latched offset/funct3 of the outstanding request.
  assign w_rdata_sh = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_data = w_rdata_sh;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_rdata_sh[7]}},  w_rdata_sh[7:0]};
      3'b100:  w_load_data = {24'd0,                w_rdata_sh[7:0]};
      3'b001:  w_load_data = {{16{w_rdata_sh[15]}}, w_rdata_sh[15:0]};
      3'b101:  w_load_data = {16'd0,                w_rdata_sh[15:0]};
      default: w_load_data = w_rdata_sh;
    endcase
  end

  // A flush arriving in the same cycle as the completion also kills it.
  assign w_kill_eff = r_kill || flush;

  always_comb begin
    w_state_nxt       = r_state;
    w_kill_nxt        = r_kill;
    w_timeout_err_nxt = r_timeout_err;
    w_off_nxt         = r_off;
    w_funct3_nxt      = r_funct3;
    w_we_nxt          = r_we;
    w_cnt_nxt         = r_cnt;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_rmask_nxt   = r_mem_rmask;
    w_mem_wmask_nxt   = r_mem_wmask;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_data_nxt    = r_rsp_data;
    w_rsp_tag_nxt     = r_rsp_tag;
    w_rsp_exc_nxt     = r_rsp_exc;

    case (r_state)
      ST_IDLE: begin
        w_kill_nxt = 1'b0;
        if (w_accept) begin
          w_off_nxt     = w_req_off;
          w_funct3_nxt  = req_funct3;
          w_we_nxt      = req_we;
          w_rsp_tag_nxt = req_tag;
          if (w_illegal || w_misal) begin
            // Rejected before memory: answer directly with an exception.
            w_state_nxt     = ST_DONE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_exc_nxt   = 1'b1;
            w_rsp_data_nxt  = 32'd0;
          end else begin
            w_state_nxt     = ST_REQ;
            w_mem_addr_nxt  = {req_addr[31:2], 2'b00};
            w_mem_rmask_nxt = req_we ? 4'b0000 : w_mask;
            w_mem_wmask_nxt = req_we ? w_mask  : 4'b0000;
            w_mem_wdata_nxt = req_we ? w_wdata_sh : 32'd0;
          end
        end
      end

      ST_REQ: begin
        // Masks are live for this single cycle; any mem_resp here is ignored.
        w_state_nxt     = ST_WAIT;
        w_mem_rmask_nxt = 4'b0000;
        w_mem_wmask_nxt = 4'b0000;
        w_cnt_nxt       = '0;
        if (flush) w_kill_nxt = 1'b1;
      end

      ST_WAIT: begin
        if (mem_resp) begin
          if (w_kill_eff) begin
            w_state_nxt = ST_IDLE;
            w_kill_nxt  = 1'b0;
          end else begin
            w_state_nxt     = ST_DONE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_exc_nxt   = 1'b0;
            w_rsp_data_nxt  = r_we ? 32'd0 : w_load_data;
          end
        end else if ((TIMEOUT != 0) && (r_cnt == c_cnt_last)) begin
          w_timeout_err_nxt = 1'b1;
          if (w_kill_eff) begin
            w_state_nxt = ST_IDLE;
            w_kill_nxt  = 1'b0;
          end else begin
            w_state_nxt     = ST_DONE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_exc_nxt   = 1'b1;
            w_rsp_data_nxt  = 32'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (flush) w_kill_nxt = 1'b1;
        end
      end

      ST_DONE: begin
        // Flush together with rsp_ready is simply a consumed response.
        if (rsp_ready || flush) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_kill        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_off         <= 2'b00;
      r_funct3      <= 3'b000;
      r_we          <= 1'b0;
      r_cnt         <= '0;
      r_mem_addr    <= 32'd0;
      r_mem_rmask   <= 4'b0000;
      r_mem_wmask   <= 4'b0000;
      r_mem_wdata   <= 32'd0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= 32'd0;
      r_rsp_tag     <= '0;
      r_rsp_exc     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_kill        <= w_kill_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_off         <= w_off_nxt;
      r_funct3      <= w_funct3_nxt;
      r_we          <= w_we_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_rmask   <= w_mem_rmask_nxt;
      r_mem_wmask   <= w_mem_wmask_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_data    <= w_rsp_data_nxt;
      r_rsp_tag     <= w_rsp_tag_nxt;
      r_rsp_exc     <= w_rsp_exc_nxt;
    end
  end

endmodule
`default_nettype wire
